// File: rtl/id_stage.sv
// Decode stage: register file, control decode, branch resolution in ID,
// load-use / branch-operand hazard detection and the ID/EX pipeline register.
module id_stage #(
    parameter int WB_BYPASS    = 1,
    parameter int UNDEF_EXCEPT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_dest,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_dest,
    output logic        hold_pc,
    output logic        hold_if,
    output logic        br,
    output logic [31:0] pc_branch,
    output logic        except,
    output logic [31:0] id_pc,
    output logic [31:0] id_rs_val,
    output logic [31:0] id_rt_val,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_dest,
    output logic [4:0]  id_shamt,
    output logic [3:0]  id_alu_ctrl,
    output logic        id_alu_src,
    output logic        id_reg_write,
    output logic        id_mem_read,
    output logic        id_mem_write,
    output logic        id_mem_to_reg
);

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [25:0] target;

    assign op     = inst_in[31:26];
    assign rs     = inst_in[25:21];
    assign rt     = inst_in[20:16];
    assign rd     = inst_in[15:11];
    assign funct  = inst_in[5:0];
    assign imm16  = inst_in[15:0];
    assign target = inst_in[25:0];

    logic [31:0] rf [32];
    logic [31:0] rs_val, rt_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wb_we && wb_addr != 5'd0) begin
            rf[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        rs_val = rf[rs];
        rt_val = rf[rt];
        if (WB_BYPASS != 0 && wb_we) begin
            if (wb_addr == rs) rs_val = wb_data;
            if (wb_addr == rt) rt_val = wb_data;
        end
        if (rs == 5'd0) rs_val = '0;
        if (rt == 5'd0) rt_val = '0;
    end

    logic       defined, writes, dest_rt, alu_src, mem_rd, mem_wr, zext, rt_src;
    logic       is_beq, is_bne, is_j, is_jr;
    logic [3:0] alu_ctrl;

    always_comb begin
        defined  = 1'b0;
        writes   = 1'b0;
        dest_rt  = 1'b0;
        alu_src  = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        zext     = 1'b0;
        rt_src   = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        alu_ctrl = ALU_ADD;
        case (op)
            6'h00: begin
                defined = 1'b1;
                writes  = 1'b1;
                rt_src  = 1'b1;
                case (funct)
                    6'h20, 6'h21: alu_ctrl = ALU_ADD;
                    6'h22, 6'h23: alu_ctrl = ALU_SUB;
                    6'h24:        alu_ctrl = ALU_AND;
                    6'h25:        alu_ctrl = ALU_OR;
                    6'h26:        alu_ctrl = ALU_XOR;
                    6'h27:        alu_ctrl = ALU_NOR;
                    6'h2A:        alu_ctrl = ALU_SLT;
                    6'h2B:        alu_ctrl = ALU_SLTU;
                    6'h00:        alu_ctrl = ALU_SLL;
                    6'h02:        alu_ctrl = ALU_SRL;
                    6'h03:        alu_ctrl = ALU_SRA;
                    6'h08: begin
                        writes = 1'b0;
                        rt_src = 1'b0;
                        is_jr  = 1'b1;
                    end
                    default: begin
                        defined = 1'b0;
                        writes  = 1'b0;
                        rt_src  = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                defined = 1'b1;
                writes  = 1'b1;
                dest_rt = 1'b1;
                alu_src = 1'b1;
                case (op)
                    6'h0A:   alu_ctrl = ALU_SLT;
                    6'h0B:   alu_ctrl = ALU_SLTU;
                    6'h0C:   begin alu_ctrl = ALU_AND; zext = 1'b1; end
                    6'h0D:   begin alu_ctrl = ALU_OR;  zext = 1'b1; end
                    6'h0E:   begin alu_ctrl = ALU_XOR; zext = 1'b1; end
                    6'h0F:   alu_ctrl = ALU_LUI;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            6'h23: begin
                defined = 1'b1;
                writes  = 1'b1;
                dest_rt = 1'b1;
                alu_src = 1'b1;
                mem_rd  = 1'b1;
            end
            6'h2B: begin
                defined = 1'b1;
                alu_src = 1'b1;
                mem_wr  = 1'b1;
                rt_src  = 1'b1;
            end
            6'h04: begin defined = 1'b1; rt_src = 1'b1; is_beq = 1'b1; end
            6'h05: begin defined = 1'b1; rt_src = 1'b1; is_bne = 1'b1; end
            6'h02: begin defined = 1'b1; is_j = 1'b1; end
            default: ;
        endcase
    end

    // A write to $0 is dropped here so EX/MEM never see a live $0 destination.
    logic [4:0] dest;
    logic       reg_write;
    assign dest      = writes ? (dest_rt ? rt : rd) : 5'd0;
    assign reg_write = (dest != 5'd0);

    function automatic logic pending(input logic [4:0] r, input logic e_rw, input logic [4:0] e_d,
                                     input logic m_mr, input logic [4:0] m_d);
        return (r != 5'd0) && ((e_rw && e_d == r) || (m_mr && m_d == r));
    endfunction

    logic load_use, branch_hz, stall;

    always_comb begin
        load_use  = ex_mem_read && ex_dest != 5'd0 &&
                    (ex_dest == rs || (ex_dest == rt && rt_src));
        branch_hz = ((is_beq || is_bne || is_jr) &&
                     pending(rs, ex_reg_write, ex_dest, mem_mem_read, mem_dest)) ||
                    ((is_beq || is_bne) &&
                     pending(rt, ex_reg_write, ex_dest, mem_mem_read, mem_dest));
        stall     = load_use || branch_hz;
    end

    logic [31:0] pc4, br_off, imm_ext;
    logic        taken;

    always_comb begin
        pc4     = pc_in + 32'd4;
        br_off  = {{14{imm16[15]}}, imm16, 2'b00};
        imm_ext = zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
        taken   = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) || is_j || is_jr;
        if (is_j)       pc_branch = {pc4[31:28], target, 2'b00};
        else if (is_jr) pc_branch = rs_val;
        else            pc_branch = pc4 + br_off;
        br      = taken && !stall;
        except  = (UNDEF_EXCEPT != 0) && !defined && !stall;
        hold_pc = stall;
        hold_if = stall;
    end

    always_ff @(posedge clk) begin
        if (rst || stall || !defined) begin
            id_pc         <= '0;
            id_rs_val     <= '0;
            id_rt_val     <= '0;
            id_imm        <= '0;
            id_rs         <= '0;
            id_rt         <= '0;
            id_dest       <= '0;
            id_shamt      <= '0;
            id_alu_ctrl   <= '0;
            id_alu_src    <= 1'b0;
            id_reg_write  <= 1'b0;
            id_mem_read   <= 1'b0;
            id_mem_write  <= 1'b0;
            id_mem_to_reg <= 1'b0;
        end else begin
            id_pc         <= pc_in;
            id_rs_val     <= rs_val;
            id_rt_val     <= rt_val;
            id_imm        <= imm_ext;
            id_rs         <= rs;
            id_rt         <= rt;
            id_dest       <= dest;
            id_shamt      <= inst_in[10:6];
            id_alu_ctrl   <= alu_ctrl;
            id_alu_src    <= alu_src;
            id_reg_write  <= reg_write;
            id_mem_read   <= mem_rd;
            id_mem_write  <= mem_wr;
            id_mem_to_reg <= mem_rd;
        end
    end

endmodule
